adc_cal_sequencer: RTL and testbench

- Controller that runs the power-up and on-demand recalibration sequence of the two ADC channels (gain x10 / x1) and the DTU datapath.
- Timed steps: ADC reset, calibration pulse, wait for the calibration-busy handshake, DTU reset, pipeline flush.
- Sits next to the sync unit, in the clock domain that drives the DTU core; its outputs are ORed into the existing ADC/DTU reset, cal and flush nets.
- Single-domain (non-triplicated) version; TMR is generated later by the flow.

---
 rtl/adc_cal_pkg.sv | 24 ++
 rtl/sync2ff.sv | 26 ++
 rtl/adc_cal_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_adc_cal_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_cal_pkg.sv
// rtl/adc_cal_pkg.sv - State encoding and default step lengths for the ADC/DTU calibration sequencer.
package adc_cal_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADC_RST   = 4'd1,
    SETTLE    = 4'd2,
    CAL_PULSE = 4'd3,
    WAIT_RISE = 4'd4,
    WAIT_FALL = 4'd5,
    DTU_RST   = 4'd6,
    FLUSH     = 4'd7,
    DONE      = 4'd8
  } cal_state_e;

  localparam int DEF_RST_LEN    = 16;
  localparam int DEF_SETTLE_LEN = 8;
  localparam int DEF_CAL_LEN    = 4;
  localparam int DEF_RISE_MAX   = 64;
  localparam int DEF_CAL_TMO    = 4096;
  localparam int DEF_FLUSH_LEN  = 8;
  localparam int DEF_CNT_BITS   = 16;

endpackage

// File: rtl/sync2ff.sv
// rtl/sync2ff.sv - Two-stage synchronizer bringing the ADC busy flags into the DTU clock domain.
module sync2ff #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end

  assign q = s2_q;

endmodule

// File: rtl/adc_cal_sequencer.sv
// rtl/adc_cal_sequencer.sv - ADC reset/cal/busy-handshake and DTU reset/flush sequencer.
// ADC_CAL_RETRY_EN enables one retry of the timed-out channels before cal_err is raised.
module adc_cal_sequencer
  import adc_cal_pkg::*;
#(
  parameter int RST_LEN    = DEF_RST_LEN,
  parameter int SETTLE_LEN = DEF_SETTLE_LEN,
  parameter int CAL_LEN    = DEF_CAL_LEN,
  parameter int RISE_MAX   = DEF_RISE_MAX,
  parameter int CAL_TMO    = DEF_CAL_TMO,
  parameter int FLUSH_LEN  = DEF_FLUSH_LEN,
  parameter int CNT_BITS   = DEF_CNT_BITS
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] chan_en,
  input  logic [1:0] AdcCalBusy_in,
  output logic [1:0] AdcRst_b,
  output logic [1:0] AdcCalIn,
  output logic       DtuRst_b,
  output logic       DtuFlush,
  output logic       busy,
  output logic       done,
  output logic [1:0] cal_err,
  output logic [3:0] state_dbg
);

  localparam logic [CNT_BITS-1:0] RST_LAST    = CNT_BITS'(RST_LEN - 1);
  localparam logic [CNT_BITS-1:0] SETTLE_LAST = CNT_BITS'(SETTLE_LEN - 1);
  localparam logic [CNT_BITS-1:0] CAL_LAST    = CNT_BITS'(CAL_LEN - 1);
  localparam logic [CNT_BITS-1:0] RISE_LAST   = CNT_BITS'(RISE_MAX - 1);
  localparam logic [CNT_BITS-1:0] TMO_LAST    = CNT_BITS'(CAL_TMO - 1);
  localparam logic [CNT_BITS-1:0] FLUSH_LAST  = CNT_BITS'(FLUSH_LEN - 1);

  cal_state_e          state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [1:0]          mask_q, mask_d;
  logic [1:0]          risen_q, risen_d;
  logic [1:0]          err_q, err_d;
  logic [1:0]          adc_rst_b_q, adc_rst_b_d;
  logic [1:0]          adc_cal_q, adc_cal_d;
  logic                dtu_rst_b_q, dtu_rst_b_d;
  logic                flush_q, flush_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef ADC_CAL_RETRY_EN
  logic                retry_q, retry_d;
`endif

  logic [1:0] bsy_s;
  logic [1:0] bsy_m;
  logic       fail_hit;
  logic [1:0] fail_vec;

  sync2ff #(.W(2)) u_busy_sync (
    .clock (clock),
    .rst   (rst),
    .d     (AdcCalBusy_in),
    .q     (bsy_s)
  );

  assign bsy_m = bsy_s & mask_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_BITS'(1);
    mask_d   = mask_q;
    risen_d  = risen_q;
    err_d    = err_q;
    fail_hit = 1'b0;
    fail_vec = 2'b00;
`ifdef ADC_CAL_RETRY_EN
    retry_d  = retry_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d  = chan_en;
          err_d   = 2'b00;
          risen_d = 2'b00;
`ifdef ADC_CAL_RETRY_EN
          retry_d = 1'b0;
`endif
          state_d = (chan_en == 2'b00) ? DTU_RST : ADC_RST;
        end
      end
      ADC_RST:   if (cnt_q == RST_LAST)    state_d = SETTLE;
      SETTLE:    if (cnt_q == SETTLE_LAST) state_d = CAL_PULSE;
      CAL_PULSE: begin
        // A channel already busy around the pulse counts as having risen.
        risen_d = risen_q | bsy_m;
        if (cnt_q == CAL_LAST) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        risen_d = risen_q | bsy_m;
        if ((risen_d & mask_q) == mask_q) begin
          state_d = WAIT_FALL;
        end else if (cnt_q == RISE_LAST) begin
          fail_hit = 1'b1;
          fail_vec = mask_q & ~risen_d;
        end
      end
      WAIT_FALL: begin
        if (bsy_m == 2'b00) begin
          state_d = DTU_RST;
        end else if (cnt_q == TMO_LAST) begin
          fail_hit = 1'b1;
          fail_vec = bsy_m;
        end
      end
      DTU_RST: if (cnt_q == FLUSH_LAST) state_d = FLUSH;
      FLUSH:   if (cnt_q == FLUSH_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fail_hit) begin
`ifdef ADC_CAL_RETRY_EN
      if (!retry_q) begin
        // Rerun the ADC part only for the channels that timed out.
        retry_d = 1'b1;
        mask_d  = fail_vec;
        risen_d = 2'b00;
        state_d = ADC_RST;
      end else begin
        err_d   = err_q | fail_vec;
        state_d = DTU_RST;
      end
`else
      err_d   = err_q | fail_vec;
      state_d = DTU_RST;
`endif
    end

    if (state_d != state_q || state_q == IDLE) cnt_d = '0;

    adc_rst_b_d = (state_q == ADC_RST) ? ~mask_q : 2'b11;
    adc_cal_d   = (state_q == CAL_PULSE) ? mask_q : 2'b00;
    dtu_rst_b_d = (state_q != DTU_RST);
    flush_d     = (state_q == FLUSH);
    done_d      = (state_q == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mask_q      <= 2'b00;
      risen_q     <= 2'b00;
      err_q       <= 2'b00;
      adc_rst_b_q <= 2'b11;
      adc_cal_q   <= 2'b00;
      dtu_rst_b_q <= 1'b1;
      flush_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef ADC_CAL_RETRY_EN
      retry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mask_q      <= mask_d;
      risen_q     <= risen_d;
      err_q       <= err_d;
      adc_rst_b_q <= adc_rst_b_d;
      adc_cal_q   <= adc_cal_d;
      dtu_rst_b_q <= dtu_rst_b_d;
      flush_q     <= flush_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef ADC_CAL_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

  assign AdcRst_b  = adc_rst_b_q;
  assign AdcCalIn  = adc_cal_q;
  assign DtuRst_b  = dtu_rst_b_q;
  assign DtuFlush  = flush_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cal_err   = err_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// tb/tb_adc_cal_sequencer.sv - Scoreboard bench for adc_cal_sequencer with a behavioural ADC busy model.
module tb_adc_cal_sequencer;

`ifdef ADC_CAL_RETRY_EN
  localparam int RETRY = 1;
`else
  localparam int RETRY = 0;
`endif

  logic       clock = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] chan_en;
  logic [1:0] busy_in = 2'b00;
  logic [1:0] AdcRst_b;
  logic [1:0] AdcCalIn;
  logic       DtuRst_b;
  logic       DtuFlush;
  logic       busy;
  logic       done;
  logic [1:0] cal_err;
  logic [3:0] state_dbg;

  always #5 clock = ~clock;

  adc_cal_sequencer dut (
    .clock         (clock),
    .rst           (rst),
    .start         (start),
    .chan_en       (chan_en),
    .AdcCalBusy_in (busy_in),
    .AdcRst_b      (AdcRst_b),
    .AdcCalIn      (AdcCalIn),
    .DtuRst_b      (DtuRst_b),
    .DtuFlush      (DtuFlush),
    .busy          (busy),
    .done          (done),
    .cal_err       (cal_err),
    .state_dbg     (state_dbg)
  );

  typedef struct {
    logic [1:0] err;
    int         ep0;
    int         ep1;
    int         blen;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ADC model: mode 0 = rise 3 cycles after cal falls, stay high 100; 1 = never busy; 2 = stuck busy.
  int         mode [2] = '{0, 0};
  int         ph   [2] = '{0, 0};
  int         ctr  [2] = '{0, 0};
  logic [1:0] cal_p = 2'b00;

  always @(negedge clock) begin
    for (int c = 0; c < 2; c++) begin
      if (rst) begin
        ph[c] = 0;
        busy_in[c] = 1'b0;
      end else if (mode[c] == 2) begin
        ph[c] = 0;
        busy_in[c] = 1'b1;
      end else if (mode[c] == 1) begin
        ph[c] = 0;
        busy_in[c] = 1'b0;
      end else begin
        case (ph[c])
          0: begin
            busy_in[c] = 1'b0;
            if (cal_p[c] && !AdcCalIn[c]) begin
              ph[c] = 1;
              ctr[c] = 3;
            end
          end
          1: begin
            ctr[c]--;
            if (ctr[c] == 0) begin
              busy_in[c] = 1'b1;
              ph[c] = 2;
              ctr[c] = 100;
            end
          end
          default: begin
            ctr[c]--;
            if (ctr[c] == 0) begin
              busy_in[c] = 1'b0;
              ph[c] = 0;
            end
          end
        endcase
      end
      cal_p[c] = AdcCalIn[c];
    end
  end

  int         rl0, rl1, cc0, cc1, ep0, ep1, dtu_c, fl_c, blen;
  logic       busy_p = 1'b0;
  logic [1:0] arst_p = 2'b11;

  always @(negedge clock) begin
    if (busy && !busy_p) begin
      rl0 = 0; rl1 = 0; cc0 = 0; cc1 = 0; ep0 = 0; ep1 = 0;
      dtu_c = 0; fl_c = 0; blen = 0;
    end
    if (!AdcRst_b[0]) rl0++;
    if (!AdcRst_b[1]) rl1++;
    if (AdcCalIn[0]) cc0++;
    if (AdcCalIn[1]) cc1++;
    if (arst_p[0] && !AdcRst_b[0]) ep0++;
    if (arst_p[1] && !AdcRst_b[1]) ep1++;
    if (!DtuRst_b) dtu_c++;
    if (DtuFlush) fl_c++;
    if (busy) blen++;
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        cur = sb.pop_front();
        check("cal_err", int'(cal_err), int'(cur.err));
        check("busy_at_done", int'(busy), 0);
        check("adc_rst_episodes0", ep0, cur.ep0);
        check("adc_rst_episodes1", ep1, cur.ep1);
        check("adc_rst_low0", rl0, 16 * cur.ep0);
        check("adc_rst_low1", rl1, 16 * cur.ep1);
        check("adc_cal_high0", cc0, 4 * cur.ep0);
        check("adc_cal_high1", cc1, 4 * cur.ep1);
        check("dtu_rst_low", dtu_c, 8);
        check("dtu_flush_high", fl_c, 8);
        if (cur.blen != 0) check("busy_len", blen, cur.blen);
      end
    end
    busy_p = busy;
    arst_p = AdcRst_b;
  end

  task automatic kick(input logic [1:0] en);
    @(negedge clock);
    chan_en = en;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clock);
    check("run_completed", sb.size(), 0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_adc_rst_b"}, int'(AdcRst_b), 3);
    check({tag, "_adc_cal"}, int'(AdcCalIn), 0);
    check({tag, "_dtu_rst_b"}, int'(DtuRst_b), 1);
    check({tag, "_flush"}, int'(DtuFlush), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_cal_err"}, int'(cal_err), 0);
    check({tag, "_state"}, int'(state_dbg), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    chan_en = 2'b00;
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clock);

    // nominal, both channels
    sb.push_back('{2'b00, 1, 1, 0});
    kick(2'b11);
    wait_idle(1000);

    // single channel; chan_en changes mid-run must be ignored
    sb.push_back('{2'b00, 1, 0, 0});
    kick(2'b01);
    repeat (10) @(negedge clock);
    chan_en = 2'b11;
    wait_idle(1000);

    // rise timeout on channel 1
    mode[1] = 1;
    sb.push_back('{2'b10, 0, 1 + RETRY, (1 + RETRY) * (16 + 8 + 4 + 64) + 17});
    kick(2'b10);
    wait_idle(1000);
    mode[1] = 0;

    // fall timeout: channel 0 stuck busy
    mode[0] = 2;
    repeat (5) @(negedge clock);
    sb.push_back('{2'b01, 1 + RETRY, 0, (1 + RETRY) * (16 + 8 + 4 + 1 + 4096) + 17});
    kick(2'b01);
    wait_idle(10000);
    mode[0] = 0;
    repeat (5) @(negedge clock);

    // no channels enabled; a second start during busy is ignored
    sb.push_back('{2'b00, 0, 0, 17});
    kick(2'b00);
    repeat (4) @(negedge clock);
    kick(2'b11);
    wait_idle(200);
    repeat (40) @(negedge clock);

    // async reset in WAIT_FALL, then a fresh full run
    sb.push_back('{2'b00, 1, 1, 0});
    kick(2'b11);
    for (int i = 0; i < 300 && state_dbg != 4'd5; i++) @(negedge clock);
    check("reach_wait_fall", int'(state_dbg), 5);
    repeat (3) @(negedge clock);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrun_rst");
    sb.delete();
    repeat (2) @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    sb.push_back('{2'b00, 1, 1, 0});
    kick(2'b11);
    wait_idle(1000);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
